// File: rtl/pa_dst_writer.sv
// -----------------------------------------------------------------------------
// pa_dst_writer
//   Write-back stage behind the PE array. Packed int8 result words (4 lanes)
//   arrive over the res_rdy/res_acq handshake. They are buffered in a small FIFO
//   and written to data memory as full 32-bit words. Addresses start at a
//   programmed byte base and step by 4 for each word. done pulses once after
//   the last expected word has been accepted by memory.
//
// Optional feature macro: PA_DST_WRITER_STALL_CNT_EN
//   When defined, the outputs stall_up and stall_mem are added. They are
//   saturating 32-bit counts of upstream stall cycles and memory stall cycles.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         1-cycle launch pulse (honoured only when idle)
//   dst_base      byte address of first word (sampled on accepted start)
//   dst_words     word count of transfer (sampled on accepted start)
//   res_rdy       upstream word valid
//   res_acq       upstream word accepted this cycle
//   res_data      packed result {lane3,lane2,lane1,lane0}
//   mem_wr_req    memory write request (FIFO not empty)
//   mem_wr_gnt    memory accepts the write
//   mem_wr_addr   write byte address
//   mem_wr_data   write data (FIFO head)
//   busy          transfer in progress (RUN, DRAIN, FIN)
//   done          1-cycle completion pulse
//   stall_up      (optional) cycles in RUN with res_rdy=1 and res_acq=0
//   stall_mem     (optional) cycles with mem_wr_req=1 and mem_wr_gnt=0
// -----------------------------------------------------------------------------
module pa_dst_writer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  dst_words,
  input  logic              res_rdy,
  output logic              res_acq,
  input  logic [31:0]       res_data,
  output logic              mem_wr_req,
  input  logic              mem_wr_gnt,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic              busy,
  output logic              done
`ifdef PA_DST_WRITER_STALL_CNT_EN
  ,
  output logic [31:0]       stall_up,
  output logic [31:0]       stall_mem
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   C_FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] C_WRD_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] C_ADDR_STEP = ADDR_W'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [31:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic [CNT_W-1:0]   r_words;
  logic [CNT_W-1:0]   r_in_cnt;
  logic [CNT_W-1:0]   r_out_cnt;
  logic [ADDR_W-1:0]  r_addr;

  logic               w_start_acc;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [PTR_W:0]     w_count_nxt;
  logic [CNT_W-1:0]   w_in_cnt_nxt;
  logic [CNT_W-1:0]   w_out_cnt_nxt;

  assign w_start_acc = start & (r_state == S_IDLE);
  assign w_full      = (r_count == C_FULL);
  assign w_empty     = (r_count == '0);

  // A full FIFO blocks upstream even when a pop happens in the same cycle.
  assign res_acq     = (r_state == S_RUN) & ~w_full & (r_in_cnt < r_words);
  assign w_push      = res_rdy & res_acq;
  assign mem_wr_req  = ~w_empty;
  assign w_pop       = mem_wr_req & mem_wr_gnt;

  assign mem_wr_addr = r_addr;
  assign mem_wr_data = r_mem[r_rd_ptr];
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_FIN);

  // Post-edge values of occupancy and word counters for next-state decisions.
  always_comb begin
    w_count_nxt   = r_count;
    w_in_cnt_nxt  = r_in_cnt;
    w_out_cnt_nxt = r_out_cnt;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + C_CNT_ONE;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - C_CNT_ONE;
    end else begin
      w_count_nxt = r_count;
    end
    if (w_push) begin
      w_in_cnt_nxt = r_in_cnt + C_WRD_ONE;
    end else begin
      w_in_cnt_nxt = r_in_cnt;
    end
    if (w_pop) begin
      w_out_cnt_nxt = r_out_cnt + C_WRD_ONE;
    end else begin
      w_out_cnt_nxt = r_out_cnt;
    end
  end

  // Next-state logic. Decisions use post-edge counts so that done follows
  // the final memory accept by exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (dst_words == '0) ? S_FIN : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_in_cnt_nxt == r_words) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        if ((w_count_nxt == '0) && (w_out_cnt_nxt == r_words)) begin
          w_state_nxt = S_FIN;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FIFO storage and pointers. Storage is cleared so that mem_wr_data reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= res_data;
        r_wr_ptr        <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      r_count <= w_count_nxt;
    end
  end

  // Transfer parameters, word counters and the running write address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_words   <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_addr    <= '0;
    end else if (w_start_acc) begin
      r_words   <= dst_words;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_addr    <= dst_base;
    end else begin
      r_in_cnt  <= w_in_cnt_nxt;
      r_out_cnt <= w_out_cnt_nxt;
      // The address wraps modulo 2^ADDR_W.
      if (w_pop) begin
        r_addr <= r_addr + C_ADDR_STEP;
      end
    end
  end

`ifdef PA_DST_WRITER_STALL_CNT_EN
  logic [31:0] r_stall_up;
  logic [31:0] r_stall_mem;

  assign stall_up  = r_stall_up;
  assign stall_mem = r_stall_mem;

  // Saturating stall counters. They are cleared by reset and by an accepted start.
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_stall_up  <= '0;
      r_stall_mem <= '0;
    end else begin
      if ((r_state == S_RUN) && res_rdy && !res_acq && (r_stall_up != '1)) begin
        r_stall_up <= r_stall_up + 32'd1;
      end
      if (mem_wr_req && !mem_wr_gnt && (r_stall_mem != '1)) begin
        r_stall_mem <= r_stall_mem + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pa_dst_writer.sv
module tb_pa_dst_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dst_base;
  logic [15:0] dst_words;
  logic        res_rdy;
  logic        res_acq;
  logic [31:0] res_data;
  logic        mem_wr_req;
  logic        mem_wr_gnt;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        busy;
  logic        done;
`ifdef PA_DST_WRITER_STALL_CNT_EN
  logic [31:0] stall_up;
  logic [31:0] stall_mem;
`endif

  int n_total = 0;
  int n_bad   = 0;

  pa_dst_writer #(.DEPTH(4), .ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .dst_base(dst_base), .dst_words(dst_words),
    .res_rdy(res_rdy), .res_acq(res_acq), .res_data(res_data),
    .mem_wr_req(mem_wr_req), .mem_wr_gnt(mem_wr_gnt), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .busy(busy), .done(done)
`ifdef PA_DST_WRITER_STALL_CNT_EN
    , .stall_up(stall_up), .stall_mem(stall_mem)
`endif
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [15:0] words;
    int          hold;          // gnt held low for cycles 0..hold-1
    int          exp_hold_acc;  // words accepted while gnt held low
    logic [31:0] exp_last;      // address of the final write
    bit          rand_mode;     // 50% random res_rdy/gnt
    int          restart_cyc;   // cycle to pulse a (to be ignored) start, -1 none
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] base, input int k);
    return 32'h5A00_0000 ^ (base << 4) ^ (32'(k) * 32'h0103_0507);
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int cyc = 0, sent = 0, wr = 0, acc_hold = 0, done_cnt = 0;
    int done_cyc = -1, last_wr_cyc = -1, busy_cnt = 0, acq_seen = 0, req_seen = 0;
    int st_up = 0, st_mem = 0;
    bit fin = 1'b0, saw_done = 1'b0, prev_stall = 1'b0;
    logic [31:0] last_addr = 32'd0, st_addr = 32'd0, st_data = 32'd0;
    dst_base = v.base; dst_words = v.words; start = 1'b1;
    res_rdy = 1'b0; mem_wr_gnt = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    // Garbage on the config inputs while busy must have no effect.
    dst_base = ~v.base; dst_words = 16'hFFFF;
    while (!fin && cyc < 400) begin
      res_rdy    = (sent < int'(v.words)) && (v.rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1);
      mem_wr_gnt = v.rand_mode ? ($urandom_range(0, 1) == 1) : (cyc >= v.hold);
      res_data   = pat(v.base, sent);
      start      = (cyc == v.restart_cyc);
      @(negedge clk);
      if (res_rdy && !res_acq) st_up++;
      if (mem_wr_req && !mem_wr_gnt) st_mem++;
      if (res_acq) acq_seen++;
      if (mem_wr_req) req_seen++;
      if (busy) busy_cnt++;
      if (res_rdy && res_acq) begin
        if (cyc < v.hold) acc_hold++;
        sent++;
      end
      if (prev_stall && mem_wr_req) begin
        chk($sformatf("v%0d_stall_addr", idx), mem_wr_addr, st_addr);
        chk($sformatf("v%0d_stall_data", idx), mem_wr_data, st_data);
      end
      prev_stall = mem_wr_req && !mem_wr_gnt;
      st_addr = mem_wr_addr; st_data = mem_wr_data;
      if (mem_wr_req && mem_wr_gnt) begin
        chk($sformatf("v%0d_addr%0d", idx, wr), mem_wr_addr, v.base + 32'(wr) * 32'd4);
        chk($sformatf("v%0d_data%0d", idx, wr), mem_wr_data, pat(v.base, wr));
        last_addr = mem_wr_addr; last_wr_cyc = cyc; wr++;
      end
      if (saw_done) begin
        chk($sformatf("v%0d_busy_after_done", idx), {31'd0, busy}, 32'd0);
        fin = 1'b1;
      end
      if (done) begin
        done_cnt++; done_cyc = cyc; saw_done = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; res_rdy = 1'b0; mem_wr_gnt = 1'b0;
    chk($sformatf("v%0d_in_budget", idx), {31'd0, fin}, 32'd1);
    chk($sformatf("v%0d_sent", idx), 32'(sent), 32'(v.words));
    chk($sformatf("v%0d_writes", idx), 32'(wr), 32'(v.words));
    chk($sformatf("v%0d_done_cnt", idx), 32'(done_cnt), 32'd1);
    if (v.hold > 0) chk($sformatf("v%0d_hold_acc", idx), 32'(acc_hold), 32'(v.exp_hold_acc));
    if (v.words != 16'd0) begin
      chk($sformatf("v%0d_last_addr", idx), last_addr, v.exp_last);
      chk($sformatf("v%0d_done_lat", idx), 32'(done_cyc), 32'(last_wr_cyc + 1));
    end else begin
      chk($sformatf("v%0d_no_acq", idx), 32'(acq_seen), 32'd0);
      chk($sformatf("v%0d_no_req", idx), 32'(req_seen), 32'd0);
      chk($sformatf("v%0d_busy_cycles", idx), 32'(busy_cnt), 32'd1);
      chk($sformatf("v%0d_done_cyc", idx), 32'(done_cyc), 32'd0);
    end
`ifdef PA_DST_WRITER_STALL_CNT_EN
    chk($sformatf("v%0d_stall_up", idx), stall_up, 32'(st_up));
    chk($sformatf("v%0d_stall_mem", idx), stall_mem, 32'(st_mem));
`endif
  endtask

  initial begin
    int wr;
    int dseen;
    vecs[0] = '{base: 32'h0000_1000, words: 16'd8, hold: 0, exp_hold_acc: 0,
                exp_last: 32'h0000_101C, rand_mode: 1'b0, restart_cyc: -1};
    vecs[1] = '{base: 32'h0000_2000, words: 16'd6, hold: 20, exp_hold_acc: 4,
                exp_last: 32'h0000_2014, rand_mode: 1'b0, restart_cyc: -1};
    vecs[2] = '{base: 32'h0000_0300, words: 16'd0, hold: 0, exp_hold_acc: 0,
                exp_last: 32'h0000_0000, rand_mode: 1'b0, restart_cyc: -1};
    vecs[3] = '{base: 32'hFFFF_FFF8, words: 16'd4, hold: 0, exp_hold_acc: 0,
                exp_last: 32'h0000_0004, rand_mode: 1'b0, restart_cyc: -1};
    vecs[4] = '{base: 32'h0000_0080, words: 16'd1, hold: 3, exp_hold_acc: 1,
                exp_last: 32'h0000_0080, rand_mode: 1'b0, restart_cyc: -1};
    vecs[5] = '{base: 32'h0000_A000, words: 16'd12, hold: 0, exp_hold_acc: 0,
                exp_last: 32'h0000_A02C, rand_mode: 1'b1, restart_cyc: 5};

    rst = 1'b1; start = 1'b0; dst_base = 32'd0; dst_words = 16'd0;
    res_rdy = 1'b0; res_data = 32'd0; mem_wr_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_res_acq", {31'd0, res_acq}, 32'd0);
    chk("rst_req", {31'd0, mem_wr_req}, 32'd0);
    chk("rst_addr", mem_wr_addr, 32'd0);
    chk("rst_data", mem_wr_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset in the middle of a 10-word transfer, after 3 writes have been accepted.
    dst_base = 32'h0000_4000; dst_words = 16'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wr = 0;
    for (int c = 0; c < 100 && wr < 3; c++) begin
      res_rdy = 1'b1; mem_wr_gnt = 1'b1; res_data = pat(32'h0000_4000, c);
      @(negedge clk);
      if (mem_wr_req && mem_wr_gnt) wr++;
      if (wr < 3) begin
        @(posedge clk); #1;
      end
    end
    chk("rstmid_reached3", 32'(wr), 32'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_res_acq", {31'd0, res_acq}, 32'd0);
    chk("rstmid_req", {31'd0, mem_wr_req}, 32'd0);
    chk("rstmid_addr", mem_wr_addr, 32'd0);
    chk("rstmid_data", mem_wr_data, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_done", {31'd0, done}, 32'd0);
`ifdef PA_DST_WRITER_STALL_CNT_EN
    chk("rstmid_stall_up", stall_up, 32'd0);
    chk("rstmid_stall_mem", stall_mem, 32'd0);
`endif
    dseen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done || mem_wr_req || busy) dseen++;
    end
    chk("rstmid_quiet", 32'(dseen), 32'd0);
    res_rdy = 1'b0; mem_wr_gnt = 1'b0;
    @(posedge clk); #1;

    run_vec(6, '{base: 32'h0000_5000, words: 16'd3, hold: 0, exp_hold_acc: 0,
                 exp_last: 32'h0000_5008, rand_mode: 1'b0, restart_cyc: -1});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
